qarma_wb_regs: RTL and testbench



---
 rtl/qarma_pkg.sv | 36 +++
 rtl/qarma_wb_regs_wb_slave_if.sv | 47 ++++
 rtl/qarma_wb_regs.sv | 173 +++++++++++++++++
 tb/tb_qarma_wb_regs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qarma_pkg.sv
// Shared constants, register map and sequencer states for the QARMA-64 Wishbone register bank.
package qarma_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 128;

    localparam logic [3:0] OFF_CTRL    = 4'd0;
    localparam logic [3:0] OFF_DIN_LO  = 4'd2;
    localparam logic [3:0] OFF_DIN_HI  = 4'd3;
    localparam logic [3:0] OFF_TWK_LO  = 4'd4;
    localparam logic [3:0] OFF_TWK_HI  = 4'd5;
    localparam logic [3:0] OFF_KEY0    = 4'd6;
    localparam logic [3:0] OFF_KEY1    = 4'd7;
    localparam logic [3:0] OFF_KEY2    = 4'd8;
    localparam logic [3:0] OFF_KEY3    = 4'd9;
    localparam logic [3:0] OFF_DOUT_LO = 4'd10;
    localparam logic [3:0] OFF_DOUT_HI = 4'd11;

    localparam int CTRL_START   = 0;
    localparam int CTRL_DECRYPT = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_DONE    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } seq_state_e;

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [31:0] wmask);
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

endpackage

// File: rtl/qarma_wb_regs_wb_slave_if.sv
// Wishbone classic slave front end: address decode, one-cycle ack with a forced gap,
// and per-byte write mask generation.
module wb_slave_if
    import qarma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic        i_cyc,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_adr,
    output logic        o_ack,
    output logic        o_reg_wr,
    output logic        o_reg_rd,
    output logic [3:0]  o_reg_idx,
    output logic [31:0] o_wmask
);

    logic       w_hit;
    logic       w_req;
    logic [1:0] w_unused_adr;
    logic       r_ack;

    assign w_hit        = (i_adr[31:6] == BASE_ADDR[31:6]);
    // A request is only taken while ack is low, which gives the mandatory idle cycle.
    assign w_req        = w_hit & i_stb & i_cyc & ~r_ack;
    assign w_unused_adr = i_adr[1:0];

    assign o_reg_wr  = w_req & i_we;
    assign o_reg_rd  = w_req & ~i_we;
    assign o_reg_idx = i_adr[5:2];
    assign o_wmask   = {{8{i_sel[3]}}, {8{i_sel[2]}}, {8{i_sel[1]}}, {8{i_sel[0]}}};
    assign o_ack     = r_ack;

    // Ack register: high for exactly the cycle after an accepted request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_req;
        end
    end

endmodule

// File: rtl/qarma_wb_regs.sv
// Register bank and request/result sequencer between the Wishbone bus and the
// iterative QARMA-64 core.
module qarma_wb_regs
    import qarma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                core_valid_o,
    input  logic                core_ready_i,
    output logic                core_decrypt_o,
    output logic [DATA_W-1:0]   core_data_o,
    output logic [DATA_W-1:0]   core_tweak_o,
    output logic [KEY_W-1:0]    core_key_o,
    input  logic                core_res_valid_i,
    input  logic [DATA_W-1:0]   core_res_i,
    output logic                irq_o
);

    logic              w_reg_wr;
    logic              w_reg_rd;
    logic [3:0]        w_reg_idx;
    logic [31:0]       w_wmask;
    logic [31:0]       w_rd_data;
    logic              w_busy;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_done_clr;
    logic              w_res_cap;
    seq_state_e        w_state_nxt;

    seq_state_e        r_state;
    logic              r_valid;
    logic              r_decrypt;
    logic              r_irq_en;
    logic              r_done;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_twk;
    logic [KEY_W-1:0]  r_key;
    logic [DATA_W-1:0] r_dout;
    logic [31:0]       r_dat_o;

    wb_slave_if #(.BASE_ADDR(BASE_ADDR)) u_wb_slave_if (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_stb     (wbs_stb_i),
        .i_cyc     (wbs_cyc_i),
        .i_we      (wbs_we_i),
        .i_sel     (wbs_sel_i),
        .i_adr     (wbs_adr_i),
        .o_ack     (wbs_ack_o),
        .o_reg_wr  (w_reg_wr),
        .o_reg_rd  (w_reg_rd),
        .o_reg_idx (w_reg_idx),
        .o_wmask   (w_wmask)
    );

    assign w_busy     = (r_state != IDLE);
    assign w_ctrl_wr  = w_reg_wr & (w_reg_idx == OFF_CTRL);
    assign w_start    = w_ctrl_wr & w_wmask[CTRL_START] & wbs_dat_i[CTRL_START] & ~w_busy;
    assign w_done_clr = w_start | (w_ctrl_wr & w_wmask[CTRL_DONE] & wbs_dat_i[CTRL_DONE]);
    assign w_res_cap  = (r_state == WAIT) & core_res_valid_i;

    // Sequencer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = REQ; else w_state_nxt = IDLE;
            REQ:     if (core_ready_i) w_state_nxt = WAIT; else w_state_nxt = REQ;
            WAIT:    if (core_res_valid_i) w_state_nxt = IDLE; else w_state_nxt = WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sequencer state and registered request strobe.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == REQ);
        end
    end

    // Operand registers; frozen while an operation is in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_din     <= {DATA_W{1'b0}};
            r_twk     <= {DATA_W{1'b0}};
            r_key     <= {KEY_W{1'b0}};
            r_decrypt <= 1'b0;
        end else if (w_reg_wr && !w_busy) begin
            case (w_reg_idx)
                OFF_CTRL:   if (w_wmask[CTRL_DECRYPT]) r_decrypt <= wbs_dat_i[CTRL_DECRYPT];
                OFF_DIN_LO: r_din[31:0]    <= apply_wmask(r_din[31:0],    wbs_dat_i, w_wmask);
                OFF_DIN_HI: r_din[63:32]   <= apply_wmask(r_din[63:32],   wbs_dat_i, w_wmask);
                OFF_TWK_LO: r_twk[31:0]    <= apply_wmask(r_twk[31:0],    wbs_dat_i, w_wmask);
                OFF_TWK_HI: r_twk[63:32]   <= apply_wmask(r_twk[63:32],   wbs_dat_i, w_wmask);
                OFF_KEY0:   r_key[31:0]    <= apply_wmask(r_key[31:0],    wbs_dat_i, w_wmask);
                OFF_KEY1:   r_key[63:32]   <= apply_wmask(r_key[63:32],   wbs_dat_i, w_wmask);
                OFF_KEY2:   r_key[95:64]   <= apply_wmask(r_key[95:64],   wbs_dat_i, w_wmask);
                OFF_KEY3:   r_key[127:96]  <= apply_wmask(r_key[127:96],  wbs_dat_i, w_wmask);
                default:    ;
            endcase
        end
    end

    // IRQ enable, DONE flag and result capture; a result beats a same-cycle DONE clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_dout   <= {DATA_W{1'b0}};
        end else begin
            if (w_ctrl_wr && w_wmask[CTRL_IRQ_EN]) r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            if (w_res_cap) begin
                r_done <= 1'b1;
                r_dout <= core_res_i;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    // Read multiplexer.
    always_comb begin
        w_rd_data = 32'h0;
        case (w_reg_idx)
            OFF_CTRL:    w_rd_data = {28'h0, r_done, r_irq_en, r_decrypt, w_busy};
            OFF_DIN_LO:  w_rd_data = r_din[31:0];
            OFF_DIN_HI:  w_rd_data = r_din[63:32];
            OFF_TWK_LO:  w_rd_data = r_twk[31:0];
            OFF_TWK_HI:  w_rd_data = r_twk[63:32];
            OFF_KEY0:    w_rd_data = r_key[31:0];
            OFF_KEY1:    w_rd_data = r_key[63:32];
            OFF_KEY2:    w_rd_data = r_key[95:64];
            OFF_KEY3:    w_rd_data = r_key[127:96];
            OFF_DOUT_LO: w_rd_data = r_dout[31:0];
            OFF_DOUT_HI: w_rd_data = r_dout[63:32];
            default:     w_rd_data = 32'h0;
        endcase
    end

    // Read data is registered alongside ack and returns to zero otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dat_o <= 32'h0;
        end else if (w_reg_rd) begin
            r_dat_o <= w_rd_data;
        end else begin
            r_dat_o <= 32'h0;
        end
    end

    assign wbs_dat_o      = r_dat_o;
    assign core_valid_o   = r_valid;
    assign core_decrypt_o = r_decrypt;
    assign core_data_o    = r_din;
    assign core_tweak_o   = r_twk;
    assign core_key_o     = r_key;
    assign irq_o          = r_done & r_irq_en;

endmodule

// File: tb/tb_qarma_wb_regs.sv
// Self-checking bench for qarma_wb_regs: directed sequences, a vector table and
// randomized operations against a word-level register model.
module tb_qarma_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = 32'h0, dat_i = 32'h0;
    logic         ack;
    logic [31:0]  dat_o;
    logic         core_valid, core_ready = 1'b0, core_dec;
    logic [63:0]  core_data, core_twk;
    logic [127:0] core_key;
    logic         res_valid = 1'b0;
    logic [63:0]  res = 64'h0;
    logic         irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    qarma_wb_regs #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .core_valid_o(core_valid), .core_ready_i(core_ready), .core_decrypt_o(core_dec),
        .core_data_o(core_data), .core_tweak_o(core_twk), .core_key_o(core_key),
        .core_res_valid_i(res_valid), .core_res_i(res), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transfer, then an idle edge so the next request is not blocked by ack.
    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, output logic acked, output logic [31:0] rd);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; dat_i = d;
        @(posedge clk); #1;
        acked = ack; rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] s);
        logic a; logic [31:0] r;
        bus(BASE + 32'(off * 4), 1'b1, s, d, a, r);
        chk("wr_ack", {127'h0, a}, 128'h1);
    endtask

    task automatic rd_chk(input string name, input int off, input logic [31:0] exp);
        logic a; logic [31:0] r;
        bus(BASE + 32'(off * 4), 1'b0, 4'hF, 32'h0, a, r);
        chk(name, {95'h0, a, r}, {95'h0, 1'b1, exp});
    endtask

    task automatic accept_req();
        @(negedge clk); core_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); core_ready = 1'b0;
    endtask

    task automatic pulse_result(input logic [63:0] v);
        @(negedge clk); res_valid = 1'b1; res = v;
        @(posedge clk); #1;
        @(negedge clk); res_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [3:0]  s;
        logic [31:0] d;
        logic        exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl[16];
    logic [31:0] m[16];

    initial begin
        logic        a;
        logic [31:0] r;
        logic [63:0] rv;
        int          acks, consec, prev;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", {94'h0, ack, dat_o, core_valid, irq}, 128'h0);
        @(negedge clk); rst = 1'b0;

        // Known-answer operation with a slow ready and busy-write protection
        wr(6, 32'he0a488e9, 4'hF); wr(7, 32'hec2802d4, 4'hF);
        wr(8, 32'h9804e94b, 4'hF); wr(9, 32'h84be85ce, 4'hF);
        wr(4, 32'hec0b8762, 4'hF); wr(5, 32'h477d469d, 4'hF);
        wr(2, 32'hda6e8127, 4'hF); wr(3, 32'hfb623599, 4'hF);
        wr(0, 32'h5, 4'hF);
        chk("req_valid", {127'h0, core_valid}, 128'h1);
        chk("core_key", core_key, 128'h84be85ce9804e94b_ec2802d4e0a488e9);
        chk("core_twk_data", {core_twk, core_data}, {64'h477d469dec0b8762, 64'hfb623599da6e8127});
        chk("core_dec", {127'h0, core_dec}, 128'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); res_valid = (i == 2); res = 64'hdeadbeefdeadbeef;
            @(posedge clk); #1;
            chk("req_hold", {63'h0, core_valid, core_data}, {63'h0, 1'b1, 64'hfb623599da6e8127});
        end
        @(negedge clk); res_valid = 1'b0;
        accept_req();
        chk("req_to_wait", {127'h0, core_valid}, 128'h0);
        rd_chk("ctrl_busy", 0, 32'h5);
        wr(2, 32'hffffffff, 4'hF);
        wr(0, 32'h5, 4'hF);
        chk("busy_no_rereq", {127'h0, core_valid}, 128'h0);
        rd_chk("din_lo_kept", 2, 32'hda6e8127);
        repeat (4) @(posedge clk);
        pulse_result(64'h544b0ab95bda7c3a);
        chk("irq_set", {127'h0, irq}, 128'h1);
        rd_chk("dout_lo", 10, 32'h5bda7c3a);
        rd_chk("dout_hi", 11, 32'h544b0ab9);
        rd_chk("ctrl_done", 0, 32'hC);
        wr(0, 32'h8, 4'hF);
        chk("irq_clr", {127'h0, irq}, 128'h0);
        rd_chk("ctrl_clr", 0, 32'h0);

        // Result capture racing a DONE clear: DONE must survive
        wr(0, 32'h5, 4'hF);
        accept_req();
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; dat_i = 32'hC;
        res_valid = 1'b1; res = 64'h0123456789abcdef;
        @(posedge clk); #1;
        chk("race_ack", {127'h0, ack}, 128'h1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0; res_valid = 1'b0;
        @(posedge clk); #1;
        chk("race_irq", {127'h0, irq}, 128'h1);
        rd_chk("race_ctrl", 0, 32'hC);
        rd_chk("race_dout", 10, 32'h89abcdef);

        // Reset in WAIT, then a late result
        wr(0, 32'h5, 4'hF);
        accept_req();
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst_bus", {93'h0, ack, dat_o, core_valid, irq, core_dec}, 128'h0);
        chk("rst_key", core_key, 128'h0);
        chk("rst_data", {core_twk, core_data}, 128'h0);
        @(negedge clk); rst = 1'b0;
        pulse_result(64'hffffffffffffffff);
        chk("late_irq", {127'h0, irq}, 128'h0);
        rd_chk("late_ctrl", 0, 32'h0);
        rd_chk("late_dout", 10, 32'h0);

        // Vector table: byte enables, reserved space, read-only and out-of-range addresses
        tbl[0]  = '{BASE + 32'd24, 1'b1, 4'hF, 32'h00000000, 1'b1, 32'h0};
        tbl[1]  = '{BASE + 32'd24, 1'b1, 4'h2, 32'hAABBCCDD, 1'b1, 32'h0};
        tbl[2]  = '{BASE + 32'd24, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0000CC00};
        tbl[3]  = '{BASE + 32'd52, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0};
        tbl[4]  = '{BASE + 32'd52, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[5]  = '{BASE + 32'd52, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0};
        tbl[6]  = '{BASE + 32'd4,  1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[7]  = '{BASE + 32'd4,  1'b0, 4'hF, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{BASE + 32'd28, 1'b1, 4'h9, 32'h11223344, 1'b1, 32'h0};
        tbl[9]  = '{BASE + 32'd28, 1'b0, 4'hF, 32'h0,        1'b1, 32'h11000044};
        tbl[10] = '{BASE + 32'd40, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h0};
        tbl[11] = '{BASE + 32'd40, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0};
        tbl[12] = '{32'h30000040,  1'b0, 4'hF, 32'h0,        1'b0, 32'h0};
        tbl[13] = '{32'h20000008,  1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[14] = '{32'h31000008,  1'b0, 4'hF, 32'h0,        1'b0, 32'h0};
        tbl[15] = '{BASE + 32'd8,  1'b0, 4'hF, 32'h0,        1'b1, 32'h0};
        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].d, a, r);
            chk($sformatf("tbl%0d_ack", i), {127'h0, a}, {127'h0, tbl[i].exp_ack});
            if (!tbl[i].w && tbl[i].exp_ack) chk($sformatf("tbl%0d_rd", i), {96'h0, r}, {96'h0, tbl[i].exp_rd});
        end

        // Held read strobe: ack every other cycle
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'd24;
        acks = 0; consec = 0; prev = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack && prev == 1) consec++;
            if (ack) acks++;
            prev = ack ? 1 : 0;
        end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        chk("held_ack_cnt", 128'(acks), 128'd3);
        chk("held_consec", 128'(consec), 128'd0);

        // Randomized operations against the register model
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 16; k++) m[k] = 32'h0;
        for (int it = 0; it < 20; it++) begin
            int n, off, dec, ien;
            logic [3:0]  s;
            logic [31:0] d, msk;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                off = $urandom_range(2, 9);
                s = 4'($urandom_range(0, 15));
                d = $urandom;
                wr(off, d, s);
                msk = 32'h0;
                for (int b = 0; b < 4; b++) if (s[b]) msk = msk | (32'hFF << (8 * b));
                m[off] = (m[off] & ~msk) | (d & msk);
            end
            dec = $urandom_range(0, 1);
            ien = $urandom_range(0, 1);
            wr(0, 32'(1 + 2 * dec + 4 * ien), 4'hF);
            chk("rnd_valid", {127'h0, core_valid}, 128'h1);
            chk("rnd_key", core_key, {m[9], m[8], m[7], m[6]});
            chk("rnd_twk_data", {core_twk, core_data}, {m[5], m[4], m[3], m[2]});
            chk("rnd_dec", {127'h0, core_dec}, 128'(dec));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            accept_req();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            rv = {$urandom, $urandom};
            pulse_result(rv);
            chk("rnd_irq", {127'h0, irq}, 128'(ien));
            rd_chk("rnd_dout_lo", 10, rv[31:0]);
            rd_chk("rnd_dout_hi", 11, rv[63:32]);
            rd_chk("rnd_ctrl", 0, 32'(8 + 4 * ien + 2 * dec));
            off = $urandom_range(2, 9);
            rd_chk("rnd_reg", off, m[off]);
            wr(0, 32'h8, 4'hF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
